// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, the rw
// direction bit, the controller state enum and small lane-mask helpers.
package mem_pkg;

    // Access size encodings on the size input
    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    // Direction encodings on the rw input
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Controller states; IDLE is zero so a reset state reads back as all-zero
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mauState_t;

    // Byte-lane pattern of an access anchored at lane 0
    function automatic logic [7:0] laneMask(input logic [1:0] accSize);
        case (accSize)
            SIZE_BYTE: laneMask = 8'h01;
            SIZE_HALF: laneMask = 8'h03;
            SIZE_WORD: laneMask = 8'h0F;
            default:   laneMask = 8'hFF;
        endcase
    endfunction

    // Lane-offset bits that must be zero for a naturally aligned access
    function automatic logic [7:0] offsetMask(input logic [1:0] accSize);
        case (accSize)
            SIZE_BYTE: offsetMask = 8'h00;
            SIZE_HALF: offsetMask = 8'h01;
            SIZE_WORD: offsetMask = 8'h03;
            default:   offsetMask = 8'h07;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational load aligner: picks the addressed lanes out of a memory
// word, moves them down to bit 0 and sign- or zero-extends to DATA_W.
module lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] memData,
    input  logic [OFF_W-1:0]  laneOffset,
    input  logic [1:0]        size,
    input  logic              unsign,
    output logic [DATA_W-1:0] alignedData
);

    logic [DATA_W-1:0] shifted;
    logic              signBit;
    logic              fillBit;
    int                keepBits;

    // Shift the addressed lanes to bit 0, then extend above the access width
    always_comb begin
        shifted = memData >> {laneOffset, 3'b000};
        case (size)
            SIZE_BYTE: begin keepBits = 8;      signBit = shifted[7];        end
            SIZE_HALF: begin keepBits = 16;     signBit = shifted[15];       end
            SIZE_WORD: begin keepBits = 32;     signBit = shifted[31];       end
            default:   begin keepBits = DATA_W; signBit = shifted[DATA_W-1]; end
        endcase
        fillBit = unsign ? 1'b0 : signBit;
        alignedData = '0;
        for (int i = 0; i < DATA_W; i++) begin
            alignedData[i] = (i < keepBits) ? shifted[i] : fillBit;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side memory access controller. Checks alignment, latches the access
// into MAR-side registers, strobes memory while waiting for mem_moc (with an
// optional timeout) and captures aligned/extended load data in the MDR.
// Handshake: a request is taken only in IDLE when req=1; the memory side is
// strobed with mem_en for every WAIT cycle and completes on the first cycle
// mem_moc=1 is seen while mem_en=1. done/err are one-cycle pulses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  rw,
    input  logic [1:0]            size,
    input  logic                  unsign,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic                  mem_rw,
    output logic                  mem_en,
    input  logic                  mem_moc,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [1:0]            dbgState
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    mauState_t         state, nextState;
    logic [CNT_W-1:0]  cnt, cntNext, cntInc;
    logic [ADDR_W-1:0] marReg;
    logic              rwReg;
    logic [1:0]        sizeReg;
    logic              unsignReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] rdataReg;
    logic [DATA_W-1:0] alignedData;
    logic              startAccess;
    logic              loadRdata;

    logic [OFF_W-1:0]  reqOffset;
    logic [OFF_W-1:0]  marOffset;
    logic [7:0]        alignMask;
    logic              reqMisaligned;
    logic              reqIllegal;
    logic              reqOk;
    logic [LANES-1:0]  beBase;

    assign reqOffset     = addr[OFF_W-1:0];
    assign marOffset     = marReg[OFF_W-1:0];
    assign alignMask     = offsetMask(size);
    assign reqMisaligned = (reqOffset & alignMask[OFF_W-1:0]) != '0;
    assign reqIllegal    = (size == SIZE_DWORD) && (DATA_W == 32);
    assign reqOk         = !reqMisaligned && !reqIllegal;

    // Saturating increment so the wait counter never wraps
    assign cntInc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // Next-state, counter update and datapath load strobes
    always_comb begin
        nextState   = state;
        cntNext     = cnt;
        startAccess = 1'b0;
        loadRdata   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (reqOk) begin
                        nextState   = ST_WAIT;
                        startAccess = 1'b1;
                        cntNext     = '0;
                    end else begin
                        nextState = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout in the same cycle
                if (mem_moc) begin
                    nextState = ST_DONE;
                    loadRdata = (rwReg == RW_READ);
                end else begin
                    cntNext = cntInc;
                    if ((TIMEOUT != 0) && (cntInc == CNT_LIMIT)) begin
                        nextState = ST_ERR;
                    end
                end
            end
            ST_DONE: nextState = ST_IDLE;
            ST_ERR:  nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
        end
    end

    // MAR-side access registers and the MDR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            marReg    <= '0;
            rwReg     <= 1'b0;
            sizeReg   <= SIZE_BYTE;
            unsignReg <= 1'b0;
            wdataReg  <= '0;
            rdataReg  <= '0;
        end else begin
            if (startAccess) begin
                marReg    <= addr;
                rwReg     <= rw;
                sizeReg   <= size;
                unsignReg <= unsign;
                wdataReg  <= wdata;
            end
            if (loadRdata) begin
                rdataReg <= alignedData;
            end
        end
    end

    lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) uLaneAlign (
        .memData     (mem_rdata),
        .laneOffset  (marOffset),
        .size        (sizeReg),
        .unsign      (unsignReg),
        .alignedData (alignedData)
    );

    // Replicate the right-justified store data across every lane
    always_comb begin
        case (sizeReg)
            SIZE_BYTE: mem_wdata = {LANES{wdataReg[7:0]}};
            SIZE_HALF: mem_wdata = {(LANES / 2){wdataReg[15:0]}};
            SIZE_WORD: mem_wdata = {(LANES / 4){wdataReg[31:0]}};
            default:   mem_wdata = wdataReg;
        endcase
    end

    assign beBase   = LANES'(laneMask(sizeReg));
    assign mem_be   = (state == ST_WAIT) ? (beBase << marOffset) : '0;
    assign mem_en   = (state == ST_WAIT);
    assign mem_addr = {marReg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_rw   = rwReg;
    assign rdata    = rdataReg;
    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERR);
    assign busy     = (state != ST_IDLE);
    assign dbgState = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32, TIMEOUT=15). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              rw;
    logic [1:0]        size;
    logic              unsign;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_rw;
    logic              mem_en;
    logic              mem_moc;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbgState;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rw        (rw),
        .size      (size),
        .unsign    (unsign),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rw    (mem_rw),
        .mem_en    (mem_en),
        .mem_moc   (mem_moc),
        .mem_rdata (mem_rdata),
        .dbgState  (dbgState)
    );

    // clock
    always #5 clk = ~clk;

    // Drive a request for one rising edge; returns on the following falling edge
    task automatic issueReq(input logic rwV, input logic [1:0] sizeV, input logic unsV,
                            input logic [31:0] addrV, input logic [31:0] wdataV);
        req = 1'b1; rw = rwV; size = sizeV; unsign = unsV; addr = addrV; wdata = wdataV;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Complete the access with memory data for one rising edge
    task automatic memRespond(input logic [31:0] dataV);
        mem_moc = 1'b1; mem_rdata = dataV;
        @(negedge clk);
        mem_moc = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b1; rw = 1'b1; size = 2'b10; unsign = 1'b0;
        addr = 32'h100; wdata = 32'hFFFF_FFFF; mem_moc = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk); @(negedge clk);
        checks++; if ({busy, done, err, mem_en, mem_rw} !== 5'b0) begin failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, err, mem_en, mem_rw}); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be got=%b exp=0000", mem_be); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        req = 1'b0; mem_moc = 1'b0; mem_rdata = 32'h0; wdata = 32'h0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_word_read;
        issueReq(1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL word_mem_en got=%b exp=1", mem_en); end
        checks++; if (dbgState !== 2'd1) begin failures++; $display("FAIL word_state got=%0d exp=1", dbgState); end
        checks++; if (mem_be !== 4'b1111) begin failures++; $display("FAIL word_mem_be got=%b exp=1111", mem_be); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL word_mem_addr got=%h exp=100", mem_addr); end
        checks++; if (mem_rw !== 1'b1) begin failures++; $display("FAIL word_mem_rw got=%b exp=1", mem_rw); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL word_early_done got=%b exp=0", done); end
        memRespond(32'hDEAD_BEEF);
        checks++; if ({done, err} !== 2'b10) begin failures++; $display("FAIL word_done got=%b exp=10", {done, err}); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_rdata got=%h exp=deadbeef", rdata); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL word_mem_en_done got=%b exp=0", mem_en); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL word_idle got=%b exp=00", {done, busy}); end
    endtask

    task automatic test_byte_read;
        // signed byte from lane 3
        issueReq(1'b1, 2'b00, 1'b0, 32'h103, 32'h0);
        checks++; if (mem_be !== 4'b1000) begin failures++; $display("FAIL sbyte_mem_be got=%b exp=1000", mem_be); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sbyte_mem_addr got=%h exp=100", mem_addr); end
        memRespond(32'h80FF_0000);
        checks++; if (rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL sbyte_rdata got=%h exp=ffffff80", rdata); end
        @(negedge clk);
        // signed half from lanes 3:2
        issueReq(1'b1, 2'b01, 1'b0, 32'h106, 32'h0);
        checks++; if (mem_be !== 4'b1100) begin failures++; $display("FAIL shalf_mem_be got=%b exp=1100", mem_be); end
        memRespond(32'h8001_1234);
        checks++; if (rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL shalf_rdata got=%h exp=ffff8001", rdata); end
        @(negedge clk);
        // unsigned half from lanes 1:0
        issueReq(1'b1, 2'b01, 1'b1, 32'h200, 32'h0);
        memRespond(32'h1234_F00D);
        checks++; if (rdata !== 32'h0000_F00D) begin failures++; $display("FAIL uhalf_rdata got=%h exp=0000f00d", rdata); end
        @(negedge clk);
        // unsigned byte from lane 3
        issueReq(1'b1, 2'b00, 1'b1, 32'h103, 32'h0);
        memRespond(32'h80FF_0000);
        checks++; if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL ubyte_rdata got=%h exp=00000080", rdata); end
        @(negedge clk);
    endtask

    task automatic test_half_write;
        issueReq(1'b0, 2'b01, 1'b0, 32'h102, 32'h0000_1234);
        checks++; if (mem_be !== 4'b1100) begin failures++; $display("FAIL hwr_mem_be got=%b exp=1100", mem_be); end
        checks++; if (mem_wdata !== 32'h1234_1234) begin failures++; $display("FAIL hwr_mem_wdata got=%h exp=12341234", mem_wdata); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL hwr_mem_addr got=%h exp=100", mem_addr); end
        checks++; if (mem_rw !== 1'b0) begin failures++; $display("FAIL hwr_mem_rw got=%b exp=0", mem_rw); end
        memRespond(32'hAAAA_5555);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL hwr_done got=%b exp=1", done); end
        checks++; if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL hwr_rdata_kept got=%h exp=00000080", rdata); end
        @(negedge clk);
        // byte store replicates into every lane
        issueReq(1'b0, 2'b00, 1'b0, 32'h101, 32'h0000_00A5);
        checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bwr_mem_wdata got=%h exp=a5a5a5a5", mem_wdata); end
        checks++; if (mem_be !== 4'b0010) begin failures++; $display("FAIL bwr_mem_be got=%b exp=0010", mem_be); end
        memRespond(32'h0);
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        issueReq(1'b1, 2'b10, 1'b0, 32'h101, 32'h0);
        checks++; if ({err, done} !== 2'b10) begin failures++; $display("FAIL mis_err got=%b exp=10", {err, done}); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL mis_mem_en got=%b exp=0", mem_en); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mis_busy got=%b exp=1", busy); end
        checks++; if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL mis_rdata got=%h exp=00000080", rdata); end
        @(negedge clk);
        checks++; if ({err, busy} !== 2'b00) begin failures++; $display("FAIL mis_idle got=%b exp=00", {err, busy}); end
        // doubleword is illegal on a 32-bit bus
        issueReq(1'b1, 2'b11, 1'b0, 32'h108, 32'h0);
        checks++; if ({err, mem_en} !== 2'b10) begin failures++; $display("FAIL dword_err got=%b exp=10", {err, mem_en}); end
        @(negedge clk);
        // misaligned half
        issueReq(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
        checks++; if ({err, mem_en} !== 2'b10) begin failures++; $display("FAIL mishalf_err got=%b exp=10", {err, mem_en}); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int enBad;
        enBad = 0;
        issueReq(1'b1, 2'b10, 1'b0, 32'h200, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            if (mem_en !== 1'b1 || err !== 1'b0) enBad++;
            @(negedge clk);
        end
        checks++; if (enBad !== 0) begin failures++; $display("FAIL to_wait_cycles got=%0d bad exp=0", enBad); end
        checks++; if ({err, done, busy} !== 3'b101) begin failures++; $display("FAIL to_err got=%b exp=101", {err, done, busy}); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL to_mem_en got=%b exp=0", mem_en); end
        @(negedge clk);
        checks++; if ({err, busy} !== 2'b00) begin failures++; $display("FAIL to_idle got=%b exp=00", {err, busy}); end
        checks++; if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL to_rdata got=%h exp=00000080", rdata); end
        // completion on the final cycle beats the timeout
        issueReq(1'b1, 2'b10, 1'b0, 32'h204, 32'h0);
        for (int k = 1; k <= 14; k++) @(negedge clk);
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL to_last_wait got=%b exp=1", mem_en); end
        memRespond(32'h1357_2468);
        checks++; if ({done, err} !== 2'b10) begin failures++; $display("FAIL to_moc_wins got=%b exp=10", {done, err}); end
        checks++; if (rdata !== 32'h1357_2468) begin failures++; $display("FAIL to_moc_rdata got=%h exp=13572468", rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int doneSeen;
        doneSeen = 0;
        issueReq(1'b1, 2'b10, 1'b0, 32'h300, 32'h0);
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL rmid_wait got=%b exp=1", mem_en); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({mem_en, busy} !== 2'b00) begin failures++; $display("FAIL rmid_async got=%b exp=00", {mem_en, busy}); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rmid_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata got=%h exp=0", rdata); end
        @(negedge clk);
        reset = 1'b1;
        mem_moc = 1'b1; mem_rdata = 32'hFACE_FACE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
        end
        mem_moc = 1'b0;
        checks++; if (doneSeen !== 0) begin failures++; $display("FAIL rmid_late_moc got=%0d exp=0", doneSeen); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata_after got=%h exp=0", rdata); end
    endtask

    task automatic test_back_to_back;
        issueReq(1'b1, 2'b10, 1'b0, 32'h400, 32'h0);
        // a new request while busy must be ignored
        req = 1'b1; addr = 32'h500;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h400) begin failures++; $display("FAIL b2b_ignored got=%h exp=400", mem_addr); end
        memRespond(32'hCAFE_F00D);
        checks++; if ({done, rdata} !== {1'b1, 32'hCAFE_F00D}) begin failures++;
            $display("FAIL b2b_first got=%b/%h exp=1/cafef00d", done, rdata); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
        @(negedge clk);
        req = 1'b0;
        checks++; if ({busy, mem_en} !== 2'b11) begin failures++; $display("FAIL b2b_second_start got=%b exp=11", {busy, mem_en}); end
        checks++; if (mem_addr !== 32'h500) begin failures++; $display("FAIL b2b_second_addr got=%h exp=500", mem_addr); end
        memRespond(32'h1111_2222);
        checks++; if ({done, rdata} !== {1'b1, 32'h1111_2222}) begin failures++;
            $display("FAIL b2b_second got=%b/%h exp=1/11112222", done, rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_read();
        test_half_write();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory data width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before error; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  1  CPU access request; sampled only in IDLE.
REQ-007 rw  in  1  1=read (load), 0=write (store).
REQ-008 size  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
REQ-009 unsign  in  1  1=zero-extend loads, 0=sign-extend loads.
REQ-010 addr  in  ADDR_W  byte address (MAR source).
REQ-011 wdata  in  DATA_W  store data, right-justified.
REQ-012 rdata  out  DATA_W  MDR contents: aligned and extended load data.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  one-cycle error pulse, mutually exclusive with done.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 mem_addr  out  ADDR_W  latched MAR with the lane-offset bits forced to 0.
REQ-017 mem_wdata  out  DATA_W  store data replicated across all lanes.
REQ-018 mem_be  out  DATA_W/8  byte enables.
REQ-019 mem_rw  out  1  latched rw.
REQ-020 mem_en  out  1  memory strobe; high only in WAIT.
REQ-021 mem_moc  in  1  memory operation complete.

Function
REQ-022 States: IDLE, WAIT, DONE, ERR.
REQ-023 IDLE with req=1 and a legal, aligned access: latch addr, rw, size, unsign, wdata into MAR/MDR-side registers, clear the timeout counter, and go to WAIT.
REQ-024 IDLE with req=1 and a misaligned or illegal access: go to ERR; no memory strobe is issued.
REQ-025 Misaligned means the lane offset is not a multiple of the access size in bytes; illegal means size=11 with DATA_W=32.
REQ-026 Lane offset = addr[log2(DATA_W/8)-1:0]; lanes are little-endian, with lane 0 at bits [7:0].
REQ-027 mem_be sets exactly the size-byte lanes starting at the lane offset.
REQ-028 WAIT with mem_moc=1: on reads, load the MDR with the selected lanes, shifted to bit 0 and extended per unsign; then go to DONE.
REQ-029 WAIT with mem_moc=0: increment the counter; when the counter equals TIMEOUT (and TIMEOUT≠0), go to ERR.
REQ-030 If mem_moc=1 and the timeout occur on the same cycle, mem_moc wins.
REQ-031 DONE asserts done for one cycle, then goes to IDLE; ERR asserts err for one cycle, then goes to IDLE.
REQ-032 Latency with zero-wait memory: req sampled at edge N; done is high in the cycle after edge N+1.
REQ-033 rdata holds its value until the next successful read; writes and errors leave rdata unchanged.
REQ-034 req is ignored while busy=1; mem_moc is ignored outside WAIT.
REQ-035 Timeout counter width is clog2(TIMEOUT+1) and the counter never wraps.

Reset
REQ-036 reset=0 forces IDLE immediately, including mid-access.
REQ-037 Under reset, clear the counter and MAR, set rdata=0, and drive every output to 0.

Structure
REQ-038 The shared package mem_pkg holds the size encodings, the state enum, and the rw encoding.
REQ-039 The lane extraction and extension logic is the combinational sub-module lane_align.

Verification
REQ-040 Word read at addr 0x100, memory returns 0xDEADBEEF with mem_moc on the first WAIT cycle -> mem_be=1111, done exactly 2 cycles after req, rdata=0xDEADBEEF.
REQ-041 Signed byte read at addr 0x103, memory word 0x80FF0000 -> rdata=0xFFFFFF80; the same access with unsign=1 -> rdata=0x00000080.
REQ-042 Halfword write at addr 0x102 with wdata=0x1234 -> mem_be=1100, mem_wdata=0x12341234, mem_addr=0x100, mem_rw=0.
REQ-043 Word read at addr 0x101 -> err pulse 1 cycle after req, mem_en never asserted, rdata unchanged.
REQ-044 mem_moc held low with TIMEOUT=15 -> err after the 15th WAIT cycle, then IDLE; a second case asserts mem_moc in that same final cycle -> done, not err.
REQ-045 reset asserted during WAIT -> outputs drop to 0 asynchronously; a later mem_moc pulse produces no done.
